// File: rtl/bullet_column_plotter.sv
// Bullet column plotter: diffs one column of bullet occupancy against the
// last drawn frame and streams changed cells to the VGA adapter.
module bullet_column_plotter #(
    parameter int          ROWS    = 60,
    parameter int          X_COL   = 80,
    parameter int          Y_BASE  = 0,
    parameter int          CELL_W  = 2,
    parameter int          CELL_H  = 2,
    parameter logic [2:0]  COL_UP  = 3'b010,
    parameter logic [2:0]  COL_DN  = 3'b100,
    parameter logic [2:0]  COL_HIT = 3'b111,
    parameter logic [2:0]  COL_BG  = 3'b000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            frame_tick,
    input  logic [ROWS-1:0] up_occ,
    input  logic [ROWS-1:0] down_occ,
    output logic [7:0]      x,
    output logic [6:0]      y,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            busy,
    output logic            frame_done,
    output logic            frame_overrun
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int DYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   r;
    logic [DXW-1:0]  dx;
    logic [DYW-1:0]  dy;
    logic [ROWS-1:0] new_up, new_dn, old_up, old_dn;

    logic [1:0] cell_new, cell_old;
    logic [2:0] sel_col;
    logic [6:0] row_y;
    logic       last_row, last_dx, last_dy;

    assign cell_new = {new_up[r], new_dn[r]};
    assign cell_old = {old_up[r], old_dn[r]};
    assign row_y    = 7'(Y_BASE) + 7'(r) * 7'(CELL_H);
    assign last_row = (r == RW'(ROWS - 1));
    assign last_dx  = (dx == DXW'(CELL_W - 1));
    assign last_dy  = (dy == DYW'(CELL_H - 1));

    always_comb begin
        sel_col = COL_BG;
        unique case (cell_new)
            2'b10:   sel_col = COL_UP;
            2'b01:   sel_col = COL_DN;
            2'b11:   sel_col = COL_HIT;
            default: sel_col = COL_BG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            r             <= '0;
            dx            <= '0;
            dy            <= '0;
            new_up        <= '0;
            new_dn        <= '0;
            old_up        <= '0;
            old_dn        <= '0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            // A tick arriving mid-frame is dropped, only flagged.
            frame_overrun <= frame_tick && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        new_up <= up_occ;
                        new_dn <= down_occ;
                        r      <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cell_new != cell_old) begin
                        colour <= sel_col;
                        x      <= 8'(X_COL);
                        y      <= row_y;
                        dx     <= '0;
                        dy     <= '0;
                        plot   <= 1'b1;
                        state  <= DRAW;
                    end else if (last_row) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                DRAW: begin
                    if (last_dx) begin
                        dx <= '0;
                        if (last_dy) begin
                            dy   <= '0;
                            plot <= 1'b0;
                            if (last_row) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                r     <= r + 1'b1;
                                state <= SCAN;
                            end
                        end else begin
                            dy <= dy + 1'b1;
                            x  <= 8'(X_COL);
                            y  <= row_y + 7'(dy) + 7'd1;
                        end
                    end else begin
                        dx <= dx + 1'b1;
                        x  <= 8'(X_COL) + 8'(dx) + 8'd1;
                    end
                end
                DONE: begin
                    old_up <= new_up;
                    old_dn <= new_dn;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_column_plotter.sv
// Directed bench for bullet_column_plotter: frame lengths, pixel
// streams, collision colours, overrun and mid-frame reset.
module tb_bullet_column_plotter;

    localparam int ROWS = 60;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            frame_tick = 1'b0;
    logic [ROWS-1:0] up_occ = '0;
    logic [ROWS-1:0] down_occ = '0;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot, busy, frame_done, frame_overrun;

    bullet_column_plotter dut (
        .clk           (clk),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .up_occ        (up_occ),
        .down_occ      (down_occ),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .plot          (plot),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [17:0] pq[$];
    int f_len, f_busy, f_ovr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Pulses frame_tick, then records every plotted pixel until frame_done.
    task automatic run_frame(input logic [ROWS-1:0] u,
                             input logic [ROWS-1:0] d,
                             input int ovr_at);
        int n;
        bit done;
        pq.delete();
        f_len = 0;
        f_busy = 0;
        f_ovr = 0;
        up_occ = u;
        down_occ = d;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        up_occ = ~u;
        down_occ = ~d;
        n = 1;
        done = 0;
        while (!done && n <= 400) begin
            if (busy) f_busy++;
            if (frame_overrun) f_ovr++;
            if (plot) pq.push_back({x, y, colour});
            if (frame_done) begin
                f_len = n;
                done = 1;
            end
            frame_tick = (n == ovr_at);
            step();
            n++;
        end
        frame_tick = 1'b0;
        if (busy) f_busy++;
        if (frame_overrun) f_ovr++;
    endtask

    task automatic check_cell(input string tag, input int base,
                              input int y0, input logic [2:0] col);
        logic [17:0] got, want;
        for (int k = 0; k < 4; k++) begin
            got  = (base + k < pq.size()) ? pq[base + k] : '1;
            want = {8'(80 + k % 2), 7'(y0 + k / 2), col};
            chk(tag, 32'(got), 32'(want));
        end
    endtask

    initial begin
        int cnt;
        bit seen;

        step();
        step();
        chk("reset_outs", 32'({x, y, colour, plot, busy, frame_done,
                               frame_overrun}), 32'd0);
        resetn = 1'b1;
        step();

        run_frame(60'h1, 60'h0, -1);
        chk("a_len", f_len, 65);
        chk("a_busy", f_busy, 65);
        chk("a_ovr", f_ovr, 0);
        chk("a_nplot", pq.size(), 4);
        check_cell("a_px", 0, 0, 3'b010);

        run_frame(60'h1, 60'h0, -1);
        chk("b_len", f_len, 61);
        chk("b_nplot", pq.size(), 0);

        run_frame(60'h2, 60'h0, -1);
        chk("c_len", f_len, 69);
        chk("c_nplot", pq.size(), 8);
        check_cell("c_erase", 0, 0, 3'b000);
        check_cell("c_paint", 4, 2, 3'b010);

        run_frame(60'h0, 60'h0, -1);
        chk("clr_len", f_len, 65);
        check_cell("clr_px", 0, 2, 3'b000);

        run_frame(60'h20, 60'h20, -1);
        chk("hit_len", f_len, 65);
        chk("hit_nplot", pq.size(), 4);
        check_cell("hit_px", 0, 10, 3'b111);

        run_frame(60'h0, 60'h20, -1);
        chk("dn_len", f_len, 65);
        check_cell("dn_px", 0, 10, 3'b100);

        run_frame(60'h1, 60'h0, 20);
        chk("ovr_cnt", f_ovr, 1);
        chk("ovr_len", f_len, 69);
        chk("ovr_busy", f_busy, 69);
        chk("ovr_nplot", pq.size(), 8);
        check_cell("ovr_row0", 0, 0, 3'b010);
        check_cell("ovr_row5", 4, 10, 3'b000);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || plot) cnt++;
            step();
        end
        chk("ovr_no_extra", cnt, 0);

        up_occ = 60'h9;
        down_occ = 60'h0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (plot) seen = 1;
            else step();
        end
        chk("rst_first_plot", 32'(seen), 32'd1);
        step();
        chk("rst_px2", 32'({plot, x, y}), 32'({1'b1, 8'd81, 7'd6}));
        resetn = 1'b0;
        step();
        chk("rst_outs", 32'({plot, busy}), 32'd0);
        resetn = 1'b1;
        step();

        run_frame(60'h9, 60'h0, -1);
        chk("rep_len", f_len, 69);
        chk("rep_nplot", pq.size(), 8);
        check_cell("rep_row0", 0, 0, 3'b010);
        check_cell("rep_row3", 4, 6, 3'b010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
